// File: rtl/counter_load_sequencer_pkg.sv
// Shared definitions for the modulus-47 counter and its load sequencer.
// Keeps the counter width, the largest legal count and the sequencer FSM
// encoding in one place so the counter and its controller cannot drift apart.
package counter_load_sequencer_pkg;

  // Data width of the counter output and of the preset value.
  localparam int CNT_WIDTH       = 8;
  // Largest value the counter ever shows (count range 0..46).
  localparam int CNT_MODULUS_MAX = 46;
  // Re-load attempts after a failed verify before reporting an error.
  localparam int SEQ_MAX_RETRIES = 2;

  // Width of a counter that must hold 0..max_retries; never below one bit.
  function automatic int retry_bits(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

  localparam int SEQ_RETRY_W = retry_bits(SEQ_MAX_RETRIES);

  // Sequencer states: waiting for a request, strobing the load, reading back.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2
  } seq_state_t;

endpackage

// File: rtl/counter_load_sequencer.sv
// Accepts preset requests, range-checks them, strobes the counter load for one
// cycle, then reads the counter back and retries up to MAX_RETRIES times.
// Latency: accept edge to done_out is 3 cycles; each retry adds 2 cycles.
// Backpressure: req_ready_out is high only in IDLE; the requester holds valid.
module counter_load_sequencer
  import counter_load_sequencer_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH,
  parameter int MODULUS_MAX = CNT_MODULUS_MAX,
  parameter int MAX_RETRIES = SEQ_MAX_RETRIES
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             req_valid_in,
  input  logic [WIDTH-1:0] req_value_in,
  output logic             req_ready_out,
  input  logic             abort_in,
  output logic             load_out,
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] count_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_range_out,
  output logic             err_verify_out
);

  localparam int               RETRY_W   = retry_bits(MAX_RETRIES);
  localparam logic [WIDTH-1:0] VALUE_MAX = WIDTH'(MODULUS_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  seq_state_t         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               load_q, load_d;
  logic               done_q, done_d;
  logic               err_range_q, err_range_d;
  logic               err_verify_q, err_verify_d;

  // Decoded request conditions. Abort in IDLE blocks acceptance even though
  // ready stays high, so the requester simply retries on a later edge.
  logic accept;
  logic value_ok;
  logic count_match;
  logic retries_left;

  assign accept       = (state_q == ST_IDLE) && req_valid_in && !abort_in;
  assign value_ok     = (req_value_in <= VALUE_MAX);
  assign count_match  = (count_in == d_q);
  assign retries_left = (retry_q < RETRY_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over every transition out of LOAD/VERIFY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && value_ok) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = abort_in ? ST_IDLE : ST_VERIFY;
      end
      ST_VERIFY: begin
        if (abort_in || count_match || !retries_left) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs: load strobe, captured data,
  // retry count and the three mutually exclusive status pulses.
  always_comb begin
    load_d       = 1'b0;
    d_d          = d_q;
    retry_d      = retry_q;
    done_d       = 1'b0;
    err_range_d  = 1'b0;
    err_verify_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (value_ok) begin
            d_d     = req_value_in;
            retry_d = '0;
            load_d  = 1'b1;
          end else begin
            err_range_d = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        if (!abort_in) begin
          if (count_match) begin
            done_d = 1'b1;
          end else if (retries_left) begin
            retry_d = retry_q + RETRY_W'(1);
            load_d  = 1'b1;
          end else begin
            err_verify_d = 1'b1;
          end
        end
      end
      default: begin
        // LOAD only drops the strobe; the captured value stays on d_out.
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      load_q       <= 1'b0;
      d_q          <= '0;
      retry_q      <= '0;
      done_q       <= 1'b0;
      err_range_q  <= 1'b0;
      err_verify_q <= 1'b0;
    end else begin
      load_q       <= load_d;
      d_q          <= d_d;
      retry_q      <= retry_d;
      done_q       <= done_d;
      err_range_q  <= err_range_d;
      err_verify_q <= err_verify_d;
    end
  end

  assign req_ready_out  = (state_q == ST_IDLE);
  assign busy_out       = (state_q != ST_IDLE);
  assign load_out       = load_q;
  assign d_out          = d_q;
  assign done_out       = done_q;
  assign err_range_out  = err_range_q;
  assign err_verify_out = err_verify_q;

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Directed bench: sequencer driving a modulus-47 counter (optionally stubbed so
// its read-back never matches), with hand-computed expectations per step.
module tb_counter_load_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_value;
  logic       req_ready;
  logic       abort;
  logic       load;
  logic [7:0] d;
  logic [7:0] count_mux;
  logic       busy;
  logic       done;
  logic       err_range;
  logic       err_verify;

  logic [7:0] cnt;
  logic       stub;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modulus-47 counter: load has priority, wraps to 0 once it reaches 46.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= 8'd0;
    else if (load)       cnt <= d;
    else if (cnt >= 8'd46) cnt <= 8'd0;
    else                 cnt <= cnt + 8'd1;
  end

  // The stub presents a value that never equals any legal preset.
  assign count_mux = stub ? 8'd99 : cnt;

  counter_load_sequencer dut (
    .clk            (clk),
    .reset_al_in    (rst_n),
    .req_valid_in   (req_valid),
    .req_value_in   (req_value),
    .req_ready_out  (req_ready),
    .abort_in       (abort),
    .load_out       (load),
    .d_out          (d),
    .count_in       (count_mux),
    .busy_out       (busy),
    .done_out       (done),
    .err_range_out  (err_range),
    .err_verify_out (err_verify)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int loads;
    int dones;
    int errv_at;
    logic [7:0] c_prev;

    rst_n = 1'b1; req_valid = 1'b0; req_value = 8'd0; abort = 1'b0; stub = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_load", load, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_err_verify", err_verify, 0);
    chk("rst_cnt", cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_ready", req_ready, 1);

    // Value 25: load one cycle, verify, done three cycles after accept.
    req_valid = 1'b1; req_value = 8'd25;
    step();
    req_valid = 1'b0;
    chk("v25_load", load, 1);
    chk("v25_d", d, 25);
    chk("v25_busy", busy, 1);
    chk("v25_ready", req_ready, 0);
    step();
    chk("v25_load_off", load, 0);
    chk("v25_cnt_verify", cnt, 25);
    chk("v25_done_early", done, 0);
    step();
    chk("v25_done", done, 1);
    chk("v25_busy_off", busy, 0);
    chk("v25_cnt26", cnt, 26);
    step();
    chk("v25_done_pulse", done, 0);
    chk("v25_cnt27", cnt, 27);

    // Value 46: verify sees 46, counter wraps to 0 as done pulses.
    req_valid = 1'b1; req_value = 8'd46;
    step();
    req_valid = 1'b0;
    chk("v46_load", load, 1);
    step();
    chk("v46_cnt_verify", cnt, 46);
    step();
    chk("v46_done", done, 1);
    chk("v46_err_verify", err_verify, 0);
    chk("v46_cnt_wrap", cnt, 0);

    // Out-of-range values 47 and 200: one err_range pulse each, no load.
    step();
    req_valid = 1'b1; req_value = 8'd47;
    step();
    req_valid = 1'b0;
    chk("v47_err_range", err_range, 1);
    chk("v47_load", load, 0);
    chk("v47_busy", busy, 0);
    chk("v47_d_kept", d, 46);
    c_prev = cnt;
    step();
    chk("v47_err_pulse", err_range, 0);
    chk("v47_cnt_run", cnt, (c_prev >= 8'd46) ? 8'd0 : c_prev + 8'd1);
    req_valid = 1'b1; req_value = 8'd200;
    step();
    req_valid = 1'b0;
    chk("v200_err_range", err_range, 1);
    chk("v200_load", load, 0);
    step();
    chk("v200_err_pulse", err_range, 0);
    chk("v200_load2", load, 0);

    // Stubbed counter, value 10: 3 loads, err_verify after accept + 6 edges.
    stub = 1'b1;
    req_valid = 1'b1; req_value = 8'd10;
    loads = 0; dones = 0; errv_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      req_valid = 1'b0;
      if (load) loads++;
      if (done) dones++;
      if (err_verify && errv_at < 0) errv_at = i;
    end
    chk("stub_loads", loads, 3);
    chk("stub_dones", dones, 0);
    chk("stub_errv_edge", errv_at, 7);
    chk("stub_idle", busy, 0);
    stub = 1'b0;

    // Abort during VERIFY for 5: idle next cycle, no pulses; 12 follows.
    req_valid = 1'b1; req_value = 8'd5;
    step();
    req_valid = 1'b0;
    step();
    chk("ab_in_verify", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_err_verify", err_verify, 0);
    chk("ab_load", load, 0);
    chk("ab_ready", req_ready, 1);
    req_valid = 1'b1; req_value = 8'd12;
    step();
    req_valid = 1'b0;
    chk("v12_load", load, 1);
    chk("v12_d", d, 12);
    step();
    step();
    chk("v12_done", done, 1);

    // Abort in IDLE suppresses acceptance.
    abort = 1'b1; req_valid = 1'b1; req_value = 8'd30;
    step();
    chk("ab_idle_busy", busy, 0);
    chk("ab_idle_load", load, 0);
    chk("ab_idle_ready", req_ready, 1);
    abort = 1'b0; req_valid = 1'b0;
    step();

    // Reset mid-LOAD, then value 0 completes.
    req_valid = 1'b1; req_value = 8'd33;
    step();
    req_valid = 1'b0;
    chk("rl_in_load", load, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_load", load, 0);
    chk("rl_d", d, 0);
    chk("rl_busy", busy, 0);
    chk("rl_cnt", cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rl_ready", req_ready, 1);
    req_valid = 1'b1; req_value = 8'd0;
    step();
    req_valid = 1'b0;
    chk("v0_load", load, 1);
    chk("v0_d", d, 0);
    step();
    chk("v0_cnt_verify", cnt, 0);
    step();
    chk("v0_done", done, 1);
    chk("v0_err_verify", err_verify, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_load_sequencer.md
Name: counter_load_sequencer

Overview:
Upstream load controller for the 8-bit modulus-47 up counter (count range 0..46, synchronous wrap to 0 once count reaches 46 or more).
- Accepts preset requests over a valid/ready handshake and range-checks them.
- Drives the counter's load strobe and data for exactly one cycle.
- Reads back the counter output to confirm the load took effect.
- Reports done or error.

Parameters:
WIDTH, 8, data width of request value, d_out and count_in
MODULUS_MAX, 46, largest legal preset value; values above it are rejected
MAX_RETRIES, 2, re-load attempts after a failed verify before giving up

Ports:
clk  input  1  rising-edge clock, shared with the counter
reset_al_in  input  1  asynchronous active-low reset, shared with the counter
req_valid_in  input  1  request present
req_value_in  input  WIDTH  requested preset value
req_ready_out  output  1  sequencer can accept a request (high only in IDLE)
abort_in  input  1  synchronous abort; returns to IDLE, no status pulse
load_out  output  1  drives counter load_in
d_out  output  WIDTH  drives counter d_in
count_in  input  WIDTH  counter count_out, read back for verification
busy_out  output  1  high in any state other than IDLE
done_out  output  1  one-cycle pulse: load verified
err_range_out  output  1  one-cycle pulse: request value > MODULUS_MAX, rejected
err_verify_out  output  1  one-cycle pulse: verify failed after all retries

Behaviour:
- Reset (reset_al_in low, asynchronous):
  - State goes to IDLE; retry count is 0.
  - load_out, d_out, busy_out, done_out, err_range_out and err_verify_out are all 0.
  - req_ready_out is 1 as soon as reset releases.
- Outputs are registered except req_ready_out and busy_out, which decode the state register.
- Handshake: a transfer occurs on a rising edge with req_valid_in && req_ready_out. Requests while busy are not accepted; the requester holds valid.
- IDLE:
  - On transfer with req_value_in <= MODULUS_MAX: capture the value into d_out, clear the retry count, go to LOAD.
  - On transfer with req_value_in > MODULUS_MAX: pulse err_range_out next cycle, stay IDLE, no load issued, d_out unchanged.
- LOAD (one cycle): load_out = 1 and d_out = captured value, then go to VERIFY. The counter samples the load at the edge that ends LOAD.
- VERIFY (one cycle): compare count_in with d_out.
  - Equal: pulse done_out next cycle, go to IDLE.
  - Not equal and retries < MAX_RETRIES: increment the retry count, go to LOAD.
  - Not equal and retries == MAX_RETRIES: pulse err_verify_out next cycle, go to IDLE.
- Latency:
  - Accept edge to done_out high is 3 cycles (LOAD, VERIFY, pulse).
  - Each retry adds 2 cycles.
  - Worst case to err_verify_out is 3 + 2*MAX_RETRIES cycles.
- Value 46: the counter shows 46 during VERIFY and wraps to 0 on the following edge. The verify samples in VERIFY only, so it passes.
- Value 0: legal; the verify compares count_in == 0.
- abort_in has priority over all transitions in LOAD and VERIFY:
  - Next state is IDLE; load_out is forced 0 that edge; no done or error pulse.
  - abort_in in IDLE suppresses acceptance that cycle (req_ready_out stays high, no transfer).
- Reset mid-operation: the sequence is dropped silently. The counter resets together with the sequencer, so no stale load remains.
- d_out holds its last captured value outside LOAD. The counter ignores it because load_out is 0.
- At most one of done_out, err_range_out and err_verify_out is high in any cycle.

Decomposition:
- Shared counter package:
  - State enum {IDLE, LOAD, VERIFY}.
  - MODULUS_MAX = 46 and WIDTH = 8, shared with the modulus counter so both stay consistent.
  - Retry-count width derived as clog2(MAX_RETRIES+1).
- No sub-module: a single FSM plus capture register, retry counter and comparator.
- The bench instantiates this block together with the modulus counter.

Test Plan:
- Request 25 with valid held one cycle → load_out high for 1 cycle with d_out=25; count_in=25 in VERIFY; done_out pulses 3 cycles after accept; counter continues 26, 27...
- Request 46 → done_out pulses; counter reads 46 then wraps to 0 the next cycle; no error.
- Request 47, then 200 → err_range_out pulses once per request; load_out never asserts; counter keeps free-running.
- Bench forces count_in mismatch (stub counter ignores load) with value 10 → 3 load pulses (1 + 2 retries), then err_verify_out at accept+7; no done_out.
- abort_in asserted during VERIFY for value 5 → back in IDLE next cycle, no pulses; a new request for 12 is accepted immediately and completes.
- reset_al_in pulsed low mid-LOAD → all outputs 0 at once, counter 0; after release, req_ready_out=1 and a request for 0 completes with done_out.
